// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned requests under a credit limit,
// buffers in-order responses and presents them to decode with a valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        next_ready_i,
    output logic        self_valid_o,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        misaligned_o,
    output logic        dbg_state_o
);

    // Decode handshake: an instruction transfers in a cycle where self_valid_o and
    // next_ready_i are both high; a flush in that cycle cancels the transfer.

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(BUF_DEPTH - 1);

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [31:0]     aq_mem_q [BUF_DEPTH];
    logic [AW-1:0]   aq_wr_q, aq_rd_q;
    logic [31:0]     fq_pc_q  [BUF_DEPTH];
    logic [31:0]     fq_ins_q [BUF_DEPTH];
    logic [AW-1:0]   fq_wr_q, fq_rd_q;
    logic [CW-1:0]   fq_cnt_q, fq_cnt_d;
    logic            misaligned_q;

    logic fq_empty, fq_full, req, grant, resp, push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_C) ? '0 : p + AW'(1);
    endfunction

    assign fq_empty = (fq_cnt_q == '0);
    assign fq_full  = (fq_cnt_q == DEPTH_C);

    // Credits cover both in-flight and buffered entries, so a response always has a slot.
    assign req   = !reset && (state_q == RUN) && !flush_i && ((outst_q + fq_cnt_q) < DEPTH_C);
    assign grant = req && imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp  = !reset && imem_rvalid_i && (outst_q != '0);

    assign self_valid_o = !reset && !stall_i && !fq_empty;
    assign pop          = self_valid_o && next_ready_i && !flush_i;
    assign push         = resp && (state_q == RUN) && !flush_i && (!fq_full || pop);

    always_comb begin
        outst_d = outst_q;
        if (grant && !resp) begin
            outst_d = outst_q + CW'(1);
        end else if (!grant && resp) begin
            outst_d = outst_q - CW'(1);
        end

        fq_cnt_d = fq_cnt_q;
        if (flush_i) begin
            fq_cnt_d = '0;
        end else if (push && !pop) begin
            fq_cnt_d = fq_cnt_q + CW'(1);
        end else if (!push && pop) begin
            fq_cnt_d = fq_cnt_q - CW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (flush_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        state_d = state_q;
        case (state_q)
            RUN:     if (flush_i && (outst_d != '0)) state_d = DRAIN;
            DRAIN:   if (outst_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            outst_q      <= '0;
            aq_wr_q      <= '0;
            aq_rd_q      <= '0;
            fq_wr_q      <= '0;
            fq_rd_q      <= '0;
            fq_cnt_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            outst_q      <= outst_d;
            fq_cnt_q     <= fq_cnt_d;
            misaligned_q <= flush_i && (redirect_pc_i[1:0] != 2'b00);

            // Granted addresses pair with responses in order, also while draining.
            if (grant) begin
                aq_mem_q[aq_wr_q] <= fetch_pc_q;
                aq_wr_q           <= ptr_inc(aq_wr_q);
            end
            if (resp) begin
                aq_rd_q <= ptr_inc(aq_rd_q);
            end

            if (flush_i) begin
                fq_wr_q <= '0;
                fq_rd_q <= '0;
            end else begin
                if (push) begin
                    fq_pc_q[fq_wr_q]  <= aq_mem_q[aq_rd_q];
                    fq_ins_q[fq_wr_q] <= imem_rdata_i;
                    fq_wr_q           <= ptr_inc(fq_wr_q);
                end
                if (pop) begin
                    fq_rd_q <= ptr_inc(fq_rd_q);
                end
            end
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc_q;
    assign instr_o      = (reset || fq_empty) ? 32'h0 : fq_ins_q[fq_rd_q];
    assign pc_o         = (reset || fq_empty) ? 32'h0 : fq_pc_q[fq_rd_q];
    assign misaligned_o = misaligned_q;
    assign dbg_state_o  = (state_q == DRAIN);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, an in-order
// memory responder, directed scenarios with literal expectations, and a short random mix.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, next_ready, stall, flush, gnt, rvalid;
    logic [31:0] redirect, rdata;
    logic        valid_o, req_o, mis_o, state_o;
    logic [31:0] addr_o, instr_o, pc_o;

    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid, w_req, w_mis, w_state;
    logic [31:0] w_addr, w_instr, w_pc;

    fetch_stage u_dut (
        .clk(clk), .reset(reset), .next_ready_i(next_ready), .self_valid_o(valid_o),
        .stall_i(stall), .flush_i(flush), .redirect_pc_i(redirect),
        .imem_req_o(req_o), .imem_addr_o(addr_o), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .instr_o(instr_o), .pc_o(pc_o),
        .misaligned_o(mis_o), .dbg_state_o(state_o)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
        .clk(clk), .reset(reset), .next_ready_i(1'b1), .self_valid_o(w_valid),
        .stall_i(1'b0), .flush_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
        .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata), .instr_o(w_instr), .pc_o(w_pc),
        .misaligned_o(w_mis), .dbg_state_o(w_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // memory responder
    logic [31:0] mem_q[$];
    int          mem_due_q[$];
    int          lat;
    bit          rv_en, spur, mem_fire;
    logic [31:0] w_q[$];

    // reference model: buffered {pc,instr}, in-flight pcs, count of stale in-flight
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];
    logic [63:0] m_fifo[$];
    int          m_stale;
    bit          m_mis;

    logic [31:0] gnt_log[$];
    int          gnt_cyc_log[$];
    logic [31:0] dec_pc_log[$];
    logic [31:0] dec_ins_log[$];
    int          dec_cyc_log[$];
    logic [31:0] w_gnt_log[$];
    int          mis_pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic clear_logs();
        gnt_log.delete();
        gnt_cyc_log.delete();
        dec_pc_log.delete();
        dec_ins_log.delete();
        dec_cyc_log.delete();
        mis_pulses = 0;
    endtask

    // One clock cycle: present responses, compare at negedge, advance model.
    task automatic tick();
        logic        exp_req, exp_valid;
        logic [31:0] exp_pc, exp_ins, a;
        mem_fire = 1'b0;
        if (spur) begin
            rvalid = 1'b1;
            rdata  = 32'h1234_5678;
        end else if (rv_en && mem_q.size() > 0 && mem_due_q[0] <= cyc) begin
            rvalid   = 1'b1;
            rdata    = ~mem_q[0];
            mem_fire = 1'b1;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        w_rvalid = (w_q.size() > 0);
        w_rdata  = (w_q.size() > 0) ? ~w_q[0] : 32'h0;

        @(negedge clk);
        exp_req   = !reset && (m_stale == 0) && !flush && ((m_infl.size() + m_fifo.size()) < 2);
        exp_valid = !reset && !stall && (m_fifo.size() > 0);
        if (reset || m_fifo.size() == 0) begin
            exp_pc  = 32'h0;
            exp_ins = 32'h0;
        end else begin
            exp_pc  = m_fifo[0][63:32];
            exp_ins = m_fifo[0][31:0];
        end
        check("req", 32'(req_o), 32'(exp_req));
        if (exp_req) check("addr", addr_o, m_pc);
        check("valid", 32'(valid_o), 32'(exp_valid));
        check("pc", pc_o, exp_pc);
        check("instr", instr_o, exp_ins);
        check("misaligned", 32'(mis_o), 32'(m_mis));
        check("drain", 32'(state_o), 32'(m_stale > 0));

        if (!reset && req_o && gnt) begin
            gnt_log.push_back(addr_o);
            gnt_cyc_log.push_back(cyc);
        end
        if (!reset && valid_o && next_ready && !flush) begin
            dec_pc_log.push_back(pc_o);
            dec_ins_log.push_back(instr_o);
            dec_cyc_log.push_back(cyc);
        end
        if (mis_o) mis_pulses++;
        if (!reset && w_req) w_gnt_log.push_back(w_addr);

        if (reset) begin
            m_infl.delete();
            m_fifo.delete();
            m_stale = 0;
            m_mis   = 1'b0;
            m_pc    = 32'h0;
        end else begin
            if (exp_valid && next_ready && !flush) void'(m_fifo.pop_front());
            if (rvalid && m_infl.size() > 0) begin
                a = m_infl.pop_front();
                if (m_stale > 0) m_stale--;
                else if (!flush) m_fifo.push_back({a, rdata});
            end
            if (flush) begin
                m_fifo.delete();
                m_stale = m_infl.size();
                m_pc    = {redirect[31:2], 2'b00};
                m_mis   = (redirect[1:0] != 2'b00);
            end else begin
                m_mis = 1'b0;
                if (exp_req && gnt) begin
                    m_infl.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        if (reset) begin
            mem_q.delete();
            mem_due_q.delete();
            w_q.delete();
        end else begin
            if (mem_fire) begin
                void'(mem_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (req_o && gnt) begin
                mem_q.push_back(addr_o);
                mem_due_q.push_back(cyc + lat);
            end
            if (w_rvalid) void'(w_q.pop_front());
            if (w_req) w_q.push_back(w_addr);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        int rel;
        reset = 1'b1; next_ready = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 32'h0;
        gnt = 1'b1; lat = 1; rv_en = 1'b1; spur = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        w_rvalid = 1'b0; w_rdata = 32'h0;
        m_pc = 32'h0; m_stale = 0; m_mis = 1'b0; mis_pulses = 0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_mis", 32'(mis_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);

        // release, immediate grant, 1-cycle responses
        reset = 1'b0;
        clear_logs();
        w_gnt_log.delete();
        rel = cyc;
        repeat (12) tick();
        check("s1_first_req_cycle", 32'(gnt_cyc_log.size() > 0 ? gnt_cyc_log[0] : -1), 32'(rel));
        check("s1_addr0", qget(gnt_log, 0), 32'h0);
        check("s1_addr1", qget(gnt_log, 1), 32'h4);
        check("s1_addr2", qget(gnt_log, 2), 32'h8);
        check("s1_dec_pc0", qget(dec_pc_log, 0), 32'h0);
        check("s1_dec_pc1", qget(dec_pc_log, 1), 32'h4);
        check("s1_dec_ins0", qget(dec_ins_log, 0), 32'hFFFF_FFFF);
        check("s1_dec_ins1", qget(dec_ins_log, 1), 32'hFFFF_FFFB);
        check("s1_back_to_back",
              32'(dec_cyc_log.size() > 1 ? dec_cyc_log[1] - dec_cyc_log[0] : -1), 32'd1);
        check("wrap_addr0", qget(w_gnt_log, 0), 32'hFFFF_FFF8);
        check("wrap_addr1", qget(w_gnt_log, 1), 32'hFFFF_FFFC);
        check("wrap_addr2", qget(w_gnt_log, 2), 32'h0000_0000);

        // decode not ready for 10 cycles
        next_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("s2_req_dropped", 32'(req_o), 32'd0);
        check("s2_pc_held", pc_o, 32'h0);
        check("s2_valid", 32'(valid_o), 32'd1);
        check("s2_req_count", 32'(gnt_log.size()), 32'd2);
        next_ready = 1'b1;
        repeat (8) tick();
        check("s2_dec0", qget(dec_pc_log, 0), 32'h0);
        check("s2_dec1", qget(dec_pc_log, 1), 32'h4);
        check("s2_dec2", qget(dec_pc_log, 2), 32'h8);

        // flush to 0x100 with two responses outstanding
        rv_en = 1'b0;
        do_reset();
        repeat (3) tick();
        check("s3_outstanding", 32'(mem_q.size()), 32'd2);
        flush = 1'b1;
        redirect = 32'h0000_0100;
        clear_logs();
        tick();
        flush = 1'b0;
        check("s3_in_drain", 32'(state_o), 32'd1);
        rv_en = 1'b1;
        repeat (10) tick();
        check("s3_next_addr", qget(gnt_log, 0), 32'h0000_0100);
        check("s3_first_dec", qget(dec_pc_log, 0), 32'h0000_0100);
        check("s3_first_ins", qget(dec_ins_log, 0), 32'hFFFF_FEFF);

        // misaligned redirect
        flush = 1'b1;
        redirect = 32'h0000_0203;
        clear_logs();
        tick();
        flush = 1'b0;
        check("s4_mis_now", 32'(mis_o), 32'd1);
        repeat (10) tick();
        check("s4_mis_once", 32'(mis_pulses), 32'd1);
        check("s4_addr", qget(gnt_log, 0), 32'h0000_0200);
        check("s4_dec", qget(dec_pc_log, 0), 32'h0000_0200);

        // stall with full buffer, then release
        stall = 1'b1;
        do_reset();
        repeat (6) tick();
        check("s5_valid_stalled", 32'(valid_o), 32'd0);
        check("s5_no_req", 32'(req_o), 32'd0);
        check("s5_dec_none", 32'(dec_pc_log.size()), 32'd0);
        stall = 1'b0;
        repeat (8) tick();
        check("s5_dec0", qget(dec_pc_log, 0), 32'h0);
        check("s5_dec1", qget(dec_pc_log, 1), 32'h4);
        check("s5_dec2", qget(dec_pc_log, 2), 32'h8);
        check("s5_back_to_back",
              32'(dec_cyc_log.size() > 1 ? dec_cyc_log[1] - dec_cyc_log[0] : -1), 32'd1);

        // spurious response with nothing outstanding; request held without grant
        gnt = 1'b0;
        do_reset();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("s6_spur_valid", 32'(valid_o), 32'd0);
        check("s6_req_held", 32'(req_o), 32'd1);
        repeat (3) tick();
        check("s6_addr_const", addr_o, 32'h0);
        gnt = 1'b1;
        repeat (6) tick();
        check("s6_dec0", qget(dec_pc_log, 0), 32'h0);
        check("s6_ins0", qget(dec_ins_log, 0), 32'hFFFF_FFFF);

        // random mix
        for (int i = 0; i < 300; i++) begin
            gnt        = ($urandom_range(0, 3) != 0);
            next_ready = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 7) == 0);
            lat        = $urandom_range(1, 3);
            rv_en      = ($urandom_range(0, 4) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            redirect   = $urandom;
            reset      = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
